// File: rtl/hsv_to_rgb565_if.sv
// Pixel stream bundle for the HSV to RGB565 converter: HSV beat in, RGB565 beat out.
// Names are seen from the converter, which connects through the slave modport.
interface hsv_to_rgb565_if #(
    parameter int HUE_W = 16
);
    logic [HUE_W-1:0] i_data;
    logic [7:0]       i_sat;
    logic [7:0]       i_val;
    logic             i_valid;
    logic             o_ready;
    logic [15:0]      o_data;
    logic             o_valid;
    logic             i_ready;

    modport master (
        output i_data, i_sat, i_val, i_valid, i_ready,
        input  o_ready, o_data, o_valid
    );

    modport slave (
        input  i_data, i_sat, i_val, i_valid, i_ready,
        output o_ready, o_data, o_valid
    );
endinterface

// File: rtl/hsv_to_rgb565.sv
// Four-stage HSV to RGB565 converter using the bit-exact div255 approximation.
// A single enable taken from the output stage stalls the whole pipe, and bubbles advance like beats.
module hsv_to_rgb565 #(
    parameter int HUE_W   = 16,
    parameter int HUE_MAX = 359
) (
    input logic            i_clk,
    input logic            i_rst,
    hsv_to_rgb565_if.slave bus
);
    localparam logic [HUE_W-1:0] HUE_LIM = HUE_W'(HUE_MAX);

    // Assumes 0 <= x <= 65025, so the sum always fits in 17 bits.
    function automatic logic [7:0] div255(input logic [15:0] x);
        logic [16:0] sum;
        sum = {1'b0, x} + 17'd1 + {9'd0, x[15:8]};
        return 8'(sum >> 8);
    endfunction

    function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
        return {8'd0, x} * {8'd0, y};
    endfunction

    logic en;

    logic [HUE_W-1:0] h_clamp;
    logic [2:0]       sector_c;
    logic [8:0]       base_c;
    logic [5:0]       f_c;
    logic [9:0]       f17_c;
    logic [7:0]       fs_c;

    logic       s1_valid;
    logic [2:0] s1_sector;
    logic [7:0] s1_fs;
    logic [7:0] s1_sat;
    logic [7:0] s1_val;

    logic        s2_valid;
    logic [2:0]  s2_sector;
    logic [7:0]  s2_val;
    logic [15:0] s2_a;
    logic [15:0] s2_b;
    logic [15:0] s2_c;

    logic        s3_valid;
    logic [2:0]  s3_sector;
    logic [7:0]  s3_val;
    logic [7:0]  s3_p;
    logic [15:0] s3_q2;
    logic [15:0] s3_t2;

    logic [7:0]  q_c;
    logic [7:0]  t_c;
    logic [7:0]  r_c;
    logic [7:0]  g_c;
    logic [7:0]  b_c;
    logic [15:0] pixel_c;

    logic        out_valid;
    logic [15:0] out_data;

    assign en          = ~out_valid | bus.i_ready;
    assign bus.o_ready = en;
    assign bus.o_valid = out_valid;
    assign bus.o_data  = out_data;

    // Sector found by a compare chain so no divider is needed; f is the offset inside the sector.
    always_comb begin
        h_clamp = (bus.i_data > HUE_LIM) ? HUE_LIM : bus.i_data;
        if (h_clamp >= HUE_W'(300)) begin
            sector_c = 3'd5;
            base_c   = 9'd300;
        end else if (h_clamp >= HUE_W'(240)) begin
            sector_c = 3'd4;
            base_c   = 9'd240;
        end else if (h_clamp >= HUE_W'(180)) begin
            sector_c = 3'd3;
            base_c   = 9'd180;
        end else if (h_clamp >= HUE_W'(120)) begin
            sector_c = 3'd2;
            base_c   = 9'd120;
        end else if (h_clamp >= HUE_W'(60)) begin
            sector_c = 3'd1;
            base_c   = 9'd60;
        end else begin
            sector_c = 3'd0;
            base_c   = 9'd0;
        end
        f_c   = 6'(h_clamp - HUE_W'(base_c));
        f17_c = {4'd0, f_c} * 10'd17;
        fs_c  = 8'(f17_c >> 2);
    end

    always_comb begin
        q_c = div255(s3_q2);
        t_c = div255(s3_t2);
        r_c = s3_val;
        g_c = s3_p;
        b_c = q_c;
        case (s3_sector)
            3'd0: begin r_c = s3_val; g_c = t_c;    b_c = s3_p;   end
            3'd1: begin r_c = q_c;    g_c = s3_val; b_c = s3_p;   end
            3'd2: begin r_c = s3_p;   g_c = s3_val; b_c = t_c;    end
            3'd3: begin r_c = s3_p;   g_c = q_c;    b_c = s3_val; end
            3'd4: begin r_c = t_c;    g_c = s3_p;   b_c = s3_val; end
            default: begin r_c = s3_val; g_c = s3_p; b_c = q_c;   end
        endcase
        pixel_c = {5'(r_c >> 3), 6'(g_c >> 2), 5'(b_c >> 3)};
    end

    // Only the valid bits and the output word are reset; stage data is don't-care behind a clear valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else if (en) begin
            s1_valid  <= bus.i_valid;
            s1_sector <= sector_c;
            s1_fs     <= fs_c;
            s1_sat    <= bus.i_sat;
            s1_val    <= bus.i_val;

            s2_valid  <= s1_valid;
            s2_sector <= s1_sector;
            s2_val    <= s1_val;
            s2_a      <= mul8(s1_val, 8'd255 - s1_sat);
            s2_b      <= mul8(s1_sat, s1_fs);
            s2_c      <= mul8(s1_sat, 8'd255 - s1_fs);

            s3_valid  <= s2_valid;
            s3_sector <= s2_sector;
            s3_val    <= s2_val;
            s3_p      <= div255(s2_a);
            s3_q2     <= mul8(s2_val, 8'd255 - div255(s2_b));
            s3_t2     <= mul8(s2_val, 8'd255 - div255(s2_c));

            out_valid <= s3_valid;
            out_data  <= pixel_c;
        end
    end
endmodule

// File: tb/tb_hsv_to_rgb565.sv
// Scoreboard bench for hsv_to_rgb565: directed colour cases, a stall, a reset flush, then random traffic
// checked against an arithmetic HSV model and a fixed four-enabled-cycle latency.
module tb_hsv_to_rgb565;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hsv_to_rgb565_if #(.HUE_W(16)) dut_if ();

    hsv_to_rgb565 #(.HUE_W(16), .HUE_MAX(359)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (dut_if)
    );

    typedef struct {
        logic [15:0] data;
        int          en_at;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          en_count = 0;
    int          ready_low = 0;
    bit          ready_random = 1'b0;
    bit          use_exp = 1'b0;
    logic [15:0] exp_val = 16'h0000;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0000;

    function automatic int d255(input int x);
        return (x + 1 + x / 256) / 256;
    endfunction

    function automatic logic [15:0] ref_pixel(input int h, input int s, input int v);
        int hc, sector, fs, p, q, t;
        logic [7:0] r, g, b;
        hc     = (h > 359) ? 359 : h;
        sector = hc / 60;
        fs     = ((hc % 60) * 17) / 4;
        p      = d255(v * (255 - s));
        q      = d255(v * (255 - d255(s * fs)));
        t      = d255(v * (255 - d255(s * (255 - fs))));
        case (sector)
            0: begin r = 8'(v); g = 8'(t); b = 8'(p); end
            1: begin r = 8'(q); g = 8'(v); b = 8'(p); end
            2: begin r = 8'(p); g = 8'(v); b = 8'(t); end
            3: begin r = 8'(p); g = 8'(q); b = 8'(v); end
            4: begin r = 8'(t); g = 8'(p); b = 8'(v); end
            default: begin r = 8'(v); g = 8'(p); b = 8'(q); end
        endcase
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    // Downstream: ready is forced low for a requested number of cycles, else random or always high.
    initial begin
        dut_if.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_low > 0) begin
                dut_if.i_ready = 1'b0;
                ready_low--;
            end else if (ready_random) begin
                dut_if.i_ready = ($urandom_range(0, 3) != 0);
            end else begin
                dut_if.i_ready = 1'b1;
            end
        end
    end

    task automatic checkOutput();
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            return;
        end
        checks++;
        if (dut_if.o_ready !== (!dut_if.o_valid || dut_if.i_ready)) begin
            errors++;
            $display("[TB] FAIL o_ready: got %b expected %b", dut_if.o_ready, !dut_if.o_valid || dut_if.i_ready);
        end
        if (prev_stall) begin
            checks++;
            if (dut_if.o_valid !== 1'b1 || dut_if.o_data !== prev_data) begin
                errors++;
                $display("[TB] FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                         dut_if.o_valid, dut_if.o_data, prev_data);
            end
        end
        if (dut_if.o_valid === 1'b1 && dut_if.i_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_beat: got data=%h expected no beat", dut_if.o_data);
            end else begin
                e = sb.pop_front();
                if (dut_if.o_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL data: got %h expected %h", dut_if.o_data, e.data);
                end
                checks++;
                if (en_count != e.en_at + 4) begin
                    errors++;
                    $display("[TB] FAIL latency: got %0d expected 4 enabled cycles", en_count - e.en_at);
                end
            end
        end
        if (dut_if.i_valid && dut_if.o_ready === 1'b1) begin
            e.data  = use_exp ? exp_val : ref_pixel(int'(dut_if.i_data), int'(dut_if.i_sat), int'(dut_if.i_val));
            e.en_at = en_count;
            sb.push_back(e);
        end
        prev_stall = (dut_if.o_valid === 1'b1) && !dut_if.i_ready;
        prev_data  = dut_if.o_data;
        if (dut_if.o_valid !== 1'b1 || dut_if.i_ready) en_count++;
    endtask

    always @(negedge clk) checkOutput();

    // Holds the beat until the DUT takes it; called and returning at posedge+1.
    task automatic applyStimulus(input logic [15:0] h, input logic [7:0] s, input logic [7:0] v,
                                 input bit known, input logic [15:0] expected);
        int  waited = 0;
        bit  done = 1'b0;
        dut_if.i_data  = h;
        dut_if.i_sat   = s;
        dut_if.i_val   = v;
        use_exp        = known;
        exp_val        = expected;
        dut_if.i_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (dut_if.o_ready === 1'b1 && !rst) begin
                done = 1'b1;
            end else if (++waited > 1000) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout: got no accept in %0d cycles expected accept", waited);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        dut_if.i_valid = 1'b0;
    endtask

    task automatic applyReset();
        rst            = 1'b1;
        dut_if.i_valid = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        checks++;
        if (dut_if.o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", dut_if.o_valid);
        end
        checks++;
        if (dut_if.o_data !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0000", dut_if.o_data);
        end
        rst = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d beats outstanding expected 0", sb.size());
        end
    endtask

    initial begin
        logic [15:0] h;
        dut_if.i_valid = 1'b0;
        dut_if.i_data  = '0;
        dut_if.i_sat   = '0;
        dut_if.i_val   = '0;
        applyReset();

        $display("[TB] primary colours back-to-back");
        applyStimulus(16'd0,   8'd255, 8'd255, 1'b1, 16'hF800);
        applyStimulus(16'd60,  8'd255, 8'd255, 1'b1, 16'hFFE0);
        applyStimulus(16'd120, 8'd255, 8'd255, 1'b1, 16'h07E0);
        applyStimulus(16'd240, 8'd255, 8'd255, 1'b1, 16'h001F);

        $display("[TB] grey, black and hue clamping");
        applyStimulus(16'd200,   8'd0,   8'd128, 1'b1, 16'h8410);
        applyStimulus(16'd200,   8'd255, 8'd0,   1'b1, 16'h0000);
        applyStimulus(16'd359,   8'd255, 8'd255, 1'b1, 16'hF800);
        applyStimulus(16'd400,   8'd255, 8'd255, 1'b1, 16'hF800);
        applyStimulus(16'hFFFF,  8'd255, 8'd255, 1'b1, 16'hF800);
        waitDrain();

        $display("[TB] stream with downstream stall");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'(i * 45), 8'(200 + i), 8'(150 + i * 10), 1'b0, 16'h0000);
            if (i == 4) ready_low = 3;
        end
        waitDrain();

        $display("[TB] reset with beats in flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'(30 + i * 100), 8'd255, 8'd255, 1'b0, 16'h0000);
        end
        applyReset();
        waitDrain();

        $display("[TB] random traffic");
        ready_random = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 19))
                0:       h = 16'd0;
                1:       h = 16'd359;
                2, 3:    h = 16'($urandom_range(0, 65535));
                default: h = 16'($urandom_range(0, 359));
            endcase
            applyStimulus(h, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 16'h0000);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        ready_random = 1'b0;
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
